// File: rtl/uart_tx_mmio_if.sv
// CPU store/load port of the memory-mapped UART transmitter.
// The master side is the datapath; the slave side is the peripheral.
interface uart_tx_mmio_if;
    logic        MemWrite;
    logic [31:0] Mem_WrAddr;
    logic [31:0] Mem_WrData;
    logic        uart_sel;
    logic [31:0] uart_rdata;

    modport master (
        output MemWrite,
        output Mem_WrAddr,
        output Mem_WrData,
        input  uart_sel,
        input  uart_rdata
    );

    modport slave (
        input  MemWrite,
        input  Mem_WrAddr,
        input  Mem_WrData,
        output uart_sel,
        output uart_rdata
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TX FIFO fed by CPU stores, 8N1 serializer, status readback.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_mmio_if.slave bus,
    output logic          tx,
    output logic          irq_empty
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam int          CW       = AW + 1;
    localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);
`ifdef UART_TX_PARITY_EN
    localparam logic        PAR_EN   = 1'b1;
`else
    localparam logic        PAR_EN   = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } state_t;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [CW-1:0] wptr_r, rptr_r, wptr_next_s, rptr_next_s, count_s;
    logic          full_s, empty_s;
    logic          sel_s, wr_data_s, wr_stat_s, push_s, pop_s;
    logic          ovf_r, ovf_next_s;
    state_t        state_r, state_next_s;
    logic [15:0]   timer_r, timer_next_s;
    logic          bit_done_s;
    logic [2:0]    idx_r, idx_next_s;
    logic [7:0]    shift_r, shift_next_s, head_s;
    logic          parity_r, parity_next_s;
    logic          tx_r, tx_next_s, irq_r, irq_next_s;
    logic [31:0]   status_s;
    logic          unused_bits_s;

    // Address decode, FIFO bookkeeping and the read-back mux
    always_comb begin
        sel_s         = (bus.Mem_WrAddr[31:3] == BASE_ADDR[31:3]);
        wr_data_s     = bus.MemWrite & sel_s & ~bus.Mem_WrAddr[2];
        wr_stat_s     = bus.MemWrite & sel_s & bus.Mem_WrAddr[2];
        count_s       = wptr_r - rptr_r;
        full_s        = (count_s == CW'(FIFO_DEPTH));
        empty_s       = (count_s == {CW{1'b0}});
        push_s        = wr_data_s & ~full_s;
        pop_s         = (state_r == ST_IDLE) & ~empty_s;
        wptr_next_s   = wptr_r + {{(CW-1){1'b0}}, push_s};
        rptr_next_s   = rptr_r + {{(CW-1){1'b0}}, pop_s};
        head_s        = mem_r[rptr_r[AW-1:0]];
        bit_done_s    = (timer_r == BIT_LAST);
        unused_bits_s = ^{bus.Mem_WrAddr[1:0], bus.Mem_WrData[31:8]};

        status_s            = 32'h0000_0000;
        status_s[8 +: CW]   = count_s;
        status_s[4]         = PAR_EN;
        status_s[3]         = ovf_r;
        status_s[2]         = (state_r != ST_IDLE);
        status_s[1]         = empty_s;
        status_s[0]         = full_s;
        bus.uart_sel        = sel_s;
        if (sel_s && bus.Mem_WrAddr[2]) begin
            bus.uart_rdata = status_s;
        end else begin
            bus.uart_rdata = 32'h0000_0000;
        end

        // A rejected push outranks a same-cycle clear so no overflow is ever lost
        if (wr_data_s && full_s) begin
            ovf_next_s = 1'b1;
        end else if (wr_stat_s && bus.Mem_WrData[3]) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // Serializer next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done_s && (idx_r == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_next_s = ST_PARITY;
`else
                    state_next_s = ST_STOP;
`endif
                end else begin
                    state_next_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done_s) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Serializer datapath: bit timer, bit index, shift register, latched parity
    always_comb begin
        if ((state_r == ST_IDLE) || bit_done_s || (state_next_s != state_r)) begin
            timer_next_s = 16'd0;
        end else begin
            timer_next_s = timer_r + 16'd1;
        end

        if ((state_r == ST_START) && bit_done_s) begin
            idx_next_s = 3'd0;
        end else if ((state_r == ST_DATA) && bit_done_s) begin
            idx_next_s = idx_r + 3'd1;
        end else begin
            idx_next_s = idx_r;
        end

        if (pop_s) begin
            shift_next_s  = head_s;
            parity_next_s = even_parity(head_s);
        end else if ((state_r == ST_DATA) && bit_done_s) begin
            shift_next_s  = {1'b0, shift_r[7:1]};
            parity_next_s = parity_r;
        end else begin
            shift_next_s  = shift_r;
            parity_next_s = parity_r;
        end
    end

    // Output decode from next-cycle values so tx and irq_empty can be registered without extra latency
    always_comb begin
        case (state_next_s)
            ST_IDLE:   tx_next_s = 1'b1;
            ST_START:  tx_next_s = 1'b0;
            ST_DATA:   tx_next_s = shift_next_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_next_s = parity_next_s;
`endif
            ST_STOP:   tx_next_s = 1'b1;
            default:   tx_next_s = 1'b1;
        endcase
        irq_next_s = (wptr_next_s == rptr_next_s) && (state_next_s == ST_IDLE);
    end

    // Serializer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_r <= {CW{1'b0}};
            rptr_r <= {CW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            wptr_r <= wptr_next_s;
            rptr_r <= rptr_next_s;
            if (push_s) begin
                mem_r[wptr_r[AW-1:0]] <= bus.Mem_WrData[7:0];
            end
        end
    end

    // Serializer datapath, overflow flag and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_r  <= 16'd0;
            idx_r    <= 3'd0;
            shift_r  <= 8'h00;
            parity_r <= 1'b0;
            ovf_r    <= 1'b0;
            tx_r     <= 1'b1;
            irq_r    <= 1'b1;
        end else begin
            timer_r  <= timer_next_s;
            idx_r    <= idx_next_s;
            shift_r  <= shift_next_s;
            parity_r <= parity_next_s;
            ovf_r    <= ovf_next_s;
            tx_r     <= tx_next_s;
            irq_r    <= irq_next_s;
        end
    end

    assign tx        = tx_r;
    assign irq_empty = irq_r;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: expected bytes are queued at each store and
// compared by a tx line decoder as frames arrive.
module tb_uart_tx_mmio;

    localparam int          CLK_DIV    = 4;
    localparam int          FIFO_DEPTH = 16;
    localparam logic [31:0] BASE       = 32'h0000_1000;
`ifdef UART_TX_PARITY_EN
    localparam int          FB         = 11;
    localparam logic [31:0] PAR_BIT    = 32'h0000_0010;
`else
    localparam int          FB         = 10;
    localparam logic [31:0] PAR_BIT    = 32'h0000_0000;
`endif
    localparam int          FL         = FB * CLK_DIV;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tx, irq_empty;
    int   n_vec = 0;
    int   n_err = 0;
    int   frames_seen = 0;
    logic [7:0] q[$];

    uart_tx_mmio_if bus();

    uart_tx_mmio #(
        .BASE_ADDR  (BASE),
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .tx        (tx),
        .irq_empty (irq_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] st(input int cnt, input logic ovf, input logic busy);
        return (32'(cnt) << 8) | PAR_BIT |
               {28'h0, ovf, busy, (cnt == 0), (cnt == FIFO_DEPTH)};
    endfunction

    task automatic check_status(input string tag, input logic [31:0] exp);
        bus.Mem_WrAddr = BASE + 32'd4;
        #1;
        check(tag, bus.uart_rdata, exp);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        bus.MemWrite   = 1'b1;
        bus.Mem_WrAddr = addr;
        bus.Mem_WrData = data;
        tick();
        bus.MemWrite   = 1'b0;
        bus.Mem_WrAddr = BASE + 32'd4;
        bus.Mem_WrData = 32'h0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (!(q.size() == 0 && irq_empty === 1'b1) && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_queue_left"}, q.size(), 0);
        check({tag, "_irq_empty"}, irq_empty, 1'b1);
    endtask

    // tx line decoder: samples each bit mid-cell, abandons a frame cut by reset
    initial begin : monitor
        logic [10:0] bits;
        logic        abort;
        logic [7:0]  exp;
        forever begin
            tick();
            if (reset === 1'b1 && tx === 1'b0) begin
                bits  = 11'h0;
                abort = 1'b0;
                for (int b = 0; b < FB; b++) begin
                    repeat ((b == 0) ? CLK_DIV / 2 : CLK_DIV) begin
                        tick();
                        if (reset !== 1'b1) abort = 1'b1;
                    end
                    bits[b] = tx;
                end
                if (!abort) begin
                    frames_seen++;
                    check("frame_start_bit", bits[0], 1'b0);
                    check("frame_stop_bit", bits[FB-1], 1'b1);
                    n_vec++;
                    assert (q.size() > 0) else begin
                        n_err++;
                        $error("FAIL unexpected_frame observed=0x%02h expected=none", bits[8:1]);
                    end
                    if (q.size() > 0) begin
                        exp = q.pop_front();
                        check("frame_data", bits[8:1], exp);
`ifdef UART_TX_PARITY_EN
                        check("frame_parity", bits[9], ^exp);
`endif
                    end
                end
            end
        end
    end

    initial begin
        bus.MemWrite   = 1'b0;
        bus.Mem_WrAddr = BASE + 32'd4;
        bus.Mem_WrData = 32'h0;

        // reset state
        #12;
        check("rst_tx", tx, 1'b1);
        check("rst_irq_empty", irq_empty, 1'b1);
        check_status("rst_status", st(0, 1'b0, 1'b0));
        #9 reset = 1'b1;
        tick();
        check_status("status_after_rst", st(0, 1'b0, 1'b0));

        // address decode
        bus.Mem_WrAddr = BASE + 32'd8; #1;
        check("sel_outside", bus.uart_sel, 1'b0);
        check("rdata_outside", bus.uart_rdata, 32'h0);
        bus.Mem_WrAddr = BASE; #1;
        check("sel_txdata", bus.uart_sel, 1'b1);
        check("rdata_txdata", bus.uart_rdata, 32'h0);
        bus.Mem_WrAddr = BASE + 32'd6; #1;
        check("rdata_lowbits_ignored", bus.uart_rdata, st(0, 1'b0, 1'b0));
        store(BASE + 32'd8, 32'h99);
        tick();
        check("outside_store_tx", tx, 1'b1);
        check_status("outside_store_status", st(0, 1'b0, 1'b0));

        // single frame 0x55
        q.push_back(8'h55);
        store(BASE, 32'h55);
        check("pre_fall_tx", tx, 1'b1);
        check_status("pushed_status", st(1, 1'b0, 1'b0));
        tick();
        check("tx_fall_latency", tx, 1'b0);
        check("irq_busy", irq_empty, 1'b0);
        check_status("busy_status", st(0, 1'b0, 1'b1));
        repeat (FL - 1) tick();
        check_status("last_frame_cycle_busy", st(0, 1'b0, 1'b1));
        tick();
        check_status("frame_end_idle", st(0, 1'b0, 1'b0));
        check("frame_end_irq", irq_empty, 1'b1);
        check("frames_after_single", frames_seen, 1);

        // three back-to-back frames
        q.push_back(8'h41); q.push_back(8'h42); q.push_back(8'h43);
        store(BASE, 32'h41);
        store(BASE, 32'h42);
        store(BASE, 32'h43);
        check_status("b2b_count2", st(2, 1'b0, 1'b1));
        repeat (FL - 1) tick();
        check("b2b_gap1_tx", tx, 1'b1);
        check_status("b2b_gap1_status", st(2, 1'b0, 1'b0));
        tick();
        check("b2b_start2_tx", tx, 1'b0);
        check_status("b2b_count1", st(1, 1'b0, 1'b1));
        repeat (FL) tick();
        check("b2b_gap2_tx", tx, 1'b1);
        check_status("b2b_gap2_status", st(1, 1'b0, 1'b0));
        tick();
        check("b2b_start3_tx", tx, 1'b0);
        check_status("b2b_count0", st(0, 1'b0, 1'b1));
        wait_idle("b2b_drain", 4 * FL);
        check("frames_after_b2b", frames_seen, 4);

        // overflow with the serializer busy
        q.push_back(8'hA5);
        store(BASE, 32'hA5);
        tick();
        for (int i = 0; i < 17; i++) begin
            if (i < 16) q.push_back(8'h10 + 8'(i));
            store(BASE, 32'h10 + 32'(i));
        end
        check_status("full_overflow", st(16, 1'b1, 1'b1));
        store(BASE + 32'd4, 32'h8);
        check_status("overflow_cleared", st(16, 1'b0, 1'b1));
        wait_idle("ovf_drain", 20 * FL);
        check("frames_after_ovf", frames_seen, 21);
        repeat (2 * FL) tick();
        check("dropped_byte_absent", frames_seen, 21);
        check("idle_tx_after_ovf", tx, 1'b1);

        // reset during data bit 3 of 0xC3
        q.push_back(8'hC3);
        store(BASE, 32'hC3);
        repeat (18) tick();
        reset = 1'b0;
        #1;
        check("async_rst_tx", tx, 1'b1);
        check("async_rst_irq", irq_empty, 1'b1);
        check_status("async_rst_status", st(0, 1'b0, 1'b0));
        q.delete();
        #20 reset = 1'b1;
        tick();
        repeat (3 * FL) tick();
        check("no_residual_frame", frames_seen, 21);
        check("no_residual_tx", tx, 1'b1);
        check_status("post_rst_status", st(0, 1'b0, 1'b0));

`ifdef UART_TX_PARITY_EN
        q.push_back(8'h07);
        store(BASE, 32'h07);
        wait_idle("parity_07", 2 * FL);
        q.push_back(8'h03);
        store(BASE, 32'h03);
        wait_idle("parity_03", 2 * FL);
        check("frames_after_parity", frames_seen, 23);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmit peripheral on the CPU store/load path, directly downstream of the single-cycle datapath.
- Consumes the datapath's data-memory address and write-data outputs plus the controller's memory-write strobe.
- Stores that hit its address window push bytes into a TX FIFO. An internal serializer drains the FIFO onto a single tx line (8N1).
- Loads that hit the window return a combinational status word, which is muxed into the read-data path.

Parameters:
- BASE_ADDR, 32'h0000_1000, base of the 8-byte register window; bits [2:0] must be 0.
- CLK_DIV, 16, clk cycles per UART bit; legal range 2..65535.
- FIFO_DEPTH, 16, TX FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- MemWrite  in  1  store strobe from the controller.
- Mem_WrAddr  in  32  load/store address (ALU result).
- Mem_WrData  in  32  store data (rs2).
- uart_sel  out  1  combinational: Mem_WrAddr[31:3] == BASE_ADDR[31:3]; steers the external read mux.
- uart_rdata  out  32  combinational status/readback word.
- tx  out  1  serial output; idles high.
- irq_empty  out  1  1 when FIFO empty and serializer idle.

Behaviour:
- Register map, word-aligned, offset = Mem_WrAddr[2]:
  - Offset 0 (TXDATA): write pushes Mem_WrData[7:0]; read returns 0.
  - Offset 4 (STATUS): read returns {count in [8+:CW], 4'b0, overflow[3], busy[2], empty[1], full[0]}, where CW = log2(FIFO_DEPTH)+1; all other bits 0. A write with Mem_WrData[3]=1 clears overflow; other written bits are ignored.
  - Mem_WrAddr[1:0] is ignored.
- Push: occurs on the rising edge when MemWrite & uart_sel & ~Mem_WrAddr[2] & ~full.
- Push while full: data dropped, overflow set to 1 (sticky), count unchanged. A push is rejected when full even if a pop happens in the same cycle.
- Overflow set and clear in the same cycle: set wins.
- FIFO: circular buffer with read/write pointers of log2(FIFO_DEPTH)+1 bits; pointers wrap naturally. count = wptr - rptr; full = (count == FIFO_DEPTH); empty = (count == 0).
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO not empty, pop the head into an 8-bit shift register and go to START. The pop and the state change happen on the same edge.
  - START: tx=0 for CLK_DIV cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] for CLK_DIV cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles, then IDLE.
  - Back-to-back frames: IDLE lasts exactly 1 cycle between frames when the FIFO is not empty.
- Bit timer: counts 0..CLK_DIV-1, resets on every state change.
- busy = (state != IDLE).
- Latency: for a store accepted at edge N into an empty, idle block, tx falls at edge N+1. The frame then lasts exactly 10*CLK_DIV cycles.
- Simultaneous push and pop on a non-full FIFO: both occur, count unchanged.
- Reset (asynchronous, active-low), applied at any time including mid-frame:
  - tx=1, state=IDLE, pointers=0, overflow=0, timer=0, shift register=0.
  - uart_rdata reflects empty=1 immediately.
- Registers are updated only by the address decode described here. Non-matching addresses have no effect.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for CLK_DIV cycles, making the frame 11*CLK_DIV cycles. STATUS bit 4 reads 1.
- Undefined: 8N1 framing; STATUS bit 4 reads 0; no PARITY state exists.

Test Plan:
- CLK_DIV=4. Reset, then store 0x55 to BASE+0 → tx falls at the next edge and emits 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles (40 cycles total). busy=1 during the frame; irq_empty=1 afterwards.
- Store 0x41, 0x42, 0x43 on consecutive cycles → three frames with exactly 1 idle cycle between them. STATUS count reads 2, 1, 0 as each frame starts.
- Hold the serializer busy and issue 17 stores into the 16-deep FIFO → STATUS reads full=1, overflow=1, count=16. The 17th byte never appears on tx. Storing 0x8 to BASE+4 then reads overflow=0.
- Load from BASE+4 after reset → uart_rdata = 0x0000_0002. Load from BASE+8 → uart_sel=0. Store to BASE+8 → no FIFO change.
- Assert reset during bit 3 of a frame → tx=1 asynchronously, STATUS reads empty. After release, no residual frame is emitted.
- With UART_TX_PARITY_EN and store 0x07 → parity bit 1, frame length 44 cycles. Store 0x03 → parity bit 0.
